// File: rtl/mpmc11_pkg.sv
// Shared types for the mpmc11 reservation table.
// Request opcodes, the entry record and default sizing.
package mpmc11_pkg;

  localparam int D_NAR  = 8;
  localparam int D_CHW  = 4;
  localparam int D_AW   = 32;
  localparam int D_GRAN = 5;
  localparam int D_TMO  = 1023;
  localparam int D_TW   = $clog2(D_TMO);

  typedef enum logic [1:0] {
    RSV = 2'd0,
    WR  = 2'd1,
    WRC = 2'd2,
    CLR = 2'd3
  } resv_op_t;

  typedef struct packed {
    logic                   vld;
    logic [D_CHW-1:0]       ch;
    logic [D_AW-D_GRAN-1:0] gran;
    logic [D_TW-1:0]        timer;
  } resv_entry_t;

endpackage

// File: rtl/mpmc11_resv_table_if.sv
// Request/response handshake between the arbiter
// and the reservation table.
interface mpmc11_resv_table_if
  import mpmc11_pkg::*;
#(
  parameter int CHW = D_CHW,
  parameter int AW  = D_AW
);

  logic           req_valid;
  logic           req_ready;
  resv_op_t       req_op;
  logic [CHW-1:0] req_ch;
  logic [AW-1:0]  req_adr;
  logic           rsp_valid;
  logic           rsp_ok;

  modport master (
    output req_valid, req_op, req_ch, req_adr,
    input  req_ready, rsp_valid, rsp_ok
  );

  modport slave (
    input  req_valid, req_op, req_ch, req_adr,
    output req_ready, rsp_valid, rsp_ok
  );

endinterface

// File: rtl/mpmc11_resv_entry.sv
// One reservation entry: owner channel, granule,
// and a lifetime timer.
module mpmc11_resv_entry #(
  parameter int CHW = 4,
  parameter int GW  = 27,
  parameter int TMO = 1023
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           inv,
  input  logic           ten,
  input  logic [CHW-1:0] req_ch,
  input  logic [GW-1:0]  req_gran,
  output logic           vld,
  output logic           chan_hit,
  output logic           gran_hit
);

  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'((TMO > 0) ? TMO - 1 : 0);

  logic [CHW-1:0] ch;
  logic [GW-1:0]  gran;
  logic [TW-1:0]  timer;
  logic           expire;

  assign expire   = ten & vld & (timer == TLAST);
  assign chan_hit = vld & (ch == req_ch);
  assign gran_hit = vld & (gran == req_gran);

  // a reload beats expiry in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= 1'b0;
      ch    <= '0;
      gran  <= '0;
      timer <= '0;
    end else if (load) begin
      vld   <= 1'b1;
      ch    <= req_ch;
      gran  <= req_gran;
      timer <= '0;
    end else if (inv | expire) begin
      vld   <= 1'b0;
      timer <= '0;
    end else if (vld & ten) begin
      timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/mpmc11_resv_table.sv
// LR/SC reservation table shared by all controller
// channels; one request per cycle, registered result.
module mpmc11_resv_table
  import mpmc11_pkg::*;
#(
  parameter int NAR  = D_NAR,
  parameter int CHW  = D_CHW,
  parameter int AW   = D_AW,
  parameter int GRAN = D_GRAN,
  parameter int TMO  = D_TMO
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  mpmc11_resv_table_if.slave       bus,
  output logic [NAR-1:0]           resv_vld,
  output logic [$clog2(NAR+1)-1:0] occupancy
);

  localparam int GW = AW - GRAN;
  localparam int VW = (NAR > 1) ? $clog2(NAR) : 1;
  localparam int OW = $clog2(NAR + 1);

  logic           accept;
  logic [GW-1:0]  gran;
  logic [NAR-1:0] chan_hit;
  logic [NAR-1:0] gran_hit;
  logic [NAR-1:0] load;
  logic [NAR-1:0] inv;
  logic [NAR-1:0] own_sel;
  logic [NAR-1:0] free_sel;
  logic [VW-1:0]  victim;
  logic           pass;
  logic           replace;

  assign bus.req_ready = ~flush;
  assign accept = bus.req_valid & ~flush;
  assign gran   = bus.req_adr[AW-1:GRAN];
  assign pass   = |(chan_hit & gran_hit);

  for (genvar i = 0; i < NAR; i++) begin : g_ent
    mpmc11_resv_entry #(
      .CHW (CHW),
      .GW  (GW),
      .TMO (TMO)
    ) u_ent (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[i]),
      .inv      (inv[i]),
      .ten      (TMO != 0),
      .req_ch   (bus.req_ch),
      .req_gran (gran),
      .vld      (resv_vld[i]),
      .chan_hit (chan_hit[i]),
      .gran_hit (gran_hit[i])
    );
  end

  // lowest-index one-hot picks
  always_comb begin
    own_sel  = '0;
    free_sel = '0;
    for (int i = NAR - 1; i >= 0; i--) begin
      if (chan_hit[i]) begin
        own_sel    = '0;
        own_sel[i] = 1'b1;
      end
      if (!resv_vld[i]) begin
        free_sel    = '0;
        free_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    load    = '0;
    inv     = '0;
    replace = 1'b0;
    if (flush) begin
      inv = '1;
    end else if (accept) begin
      unique case (bus.req_op)
        RSV: begin
          if (|chan_hit) begin
            load = own_sel;
          end else if (!(&resv_vld)) begin
            load = free_sel;
          end else begin
            load[victim] = 1'b1;
            replace      = 1'b1;
          end
        end
        WR:  inv = gran_hit;
        WRC: inv = pass ? gran_hit : chan_hit;
        CLR: inv = chan_hit;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      victim <= '0;
    end else if (flush) begin
      victim <= '0;
    end else if (replace) begin
      if (victim == VW'(NAR - 1))
        victim <= '0;
      else
        victim <= victim + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_ok    <= 1'b0;
    end else begin
      bus.rsp_valid <= accept;
      bus.rsp_ok    <= accept &
                       ((bus.req_op != WRC) | pass);
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NAR; i++)
      occupancy = occupancy + OW'(resv_vld[i]);
  end

endmodule
